// File: rtl/hilo_sequencer_if.sv
// hilo_sequencer_if
//   Bundles the sequencer's request side (control unit) and core side
//   (multi-cycle mult/div datapath) into one interface.
//   slave  : view used by hilo_sequencer
//   master : view used by whoever drives requests and models the core
// Signals
//   start/op/rs_data/rt_data : operation request, sampled only in IDLE
//   wr_hi/wr_lo/wr_data      : mthi/mtlo writes
//   busy/done/div_zero_exc   : status back to control
//   hi/lo                    : architectural HI/LO
//   md_a/md_b/md_control     : registered operands and op select to the core
//   md_reset                 : core clear
//   md_high/md_low           : core result words
interface hilo_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        div_zero_exc;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_control;
  logic        md_reset;
  logic [31:0] md_high;
  logic [31:0] md_low;

  modport slave (
    input  start, op, rs_data, rt_data, wr_hi, wr_lo, wr_data, md_high, md_low,
    output busy, done, div_zero_exc, hi, lo, md_a, md_b, md_control, md_reset
  );

  modport master (
    output start, op, rs_data, rt_data, wr_hi, wr_lo, wr_data, md_high, md_low,
    input  busy, done, div_zero_exc, hi, lo, md_a, md_b, md_control, md_reset
  );
endinterface

// File: rtl/hilo_sequencer.sv
// hilo_sequencer
//   Sequences one multiply or divide on the external multi-cycle core and
//   owns the architectural HI/LO pair.
//   IDLE -> CLEAR (core cleared one cycle) -> RUN (N cycles) -> CAPTURE,
//   then HI/LO are written and done pulses. Divide by zero is rejected in
//   IDLE without touching the core.
// Ports
//   clk, reset : clock, synchronous active-high reset
//   bus        : hilo_sequencer_if.slave (request, status, HI/LO, core side)
// Parameters
//   MULT_CYCLES : RUN cycles for a multiply
//   DIV_CYCLES  : RUN cycles for a divide
module hilo_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 33
) (
  input  logic              clk,
  input  logic              reset,
  hilo_sequencer_if.slave   bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     md_a_q, md_b_q;
  logic            md_ctl_q;
  logic            busy_q, done_q, dz_q;
  logic            div_zero;

  assign div_zero = !bus.op && (bus.rt_data == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      md_a_q   <= '0;
      md_b_q   <= '0;
      md_ctl_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (div_zero) begin
              // reject in place: core untouched, HI/LO preserved
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end else begin
              md_a_q   <= bus.rs_data;
              md_b_q   <= bus.rt_data;
              md_ctl_q <= bus.op;
              cnt      <= bus.op ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              busy_q   <= 1'b1;
              state    <= CLEAR;
            end
          end else begin
            // mthi/mtlo only when no request competes for HI/LO
            if (bus.wr_hi) hi_q <= bus.wr_data;
            if (bus.wr_lo) lo_q <= bus.wr_data;
          end
        end
        CLEAR: begin
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          if (md_ctl_q) begin
            hi_q <= bus.md_high;
            lo_q <= bus.md_low;
          end else begin
            // core reports quotient on high, remainder on low
            hi_q <= bus.md_low;
            lo_q <= bus.md_high;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.md_reset     = reset || (state == CLEAR);
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.div_zero_exc = dz_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.md_a         = md_a_q;
  assign bus.md_b         = md_b_q;
  assign bus.md_control   = md_ctl_q;

endmodule

// File: tb/tb_hilo_sequencer.sv
module tb_hilo_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_sequencer_if bus();

  hilo_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(33)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // behavioural core: signed product, or signed quotient(high)/remainder(low)
  logic [63:0]        prod;
  logic signed [31:0] sa, sb, q, r;
  always_comb begin
    prod = {{32{bus.md_a[31]}}, bus.md_a} * {{32{bus.md_b[31]}}, bus.md_b};
    sa = bus.md_a;
    sb = bus.md_b;
    q  = 32'sd0;
    r  = 32'sd0;
    if (sb != 32'sd0) begin
      q = sa / sb;
      r = sa % sb;
    end
    if (bus.md_control) begin
      bus.md_high = prod[63:32];
      bus.md_low  = prod[31:0];
    end else begin
      bus.md_high = q;
      bus.md_low  = r;
    end
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit mon_en = 0;
  bit mdr_seen = 0;

  always @(posedge clk) begin
    if (bus.done) done_cnt++;
    if (mon_en && bus.md_reset) mdr_seen = 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // counts edges after the accepting edge until done is visible
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = n; break; end
    end
  endtask

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] rs, rt, exp_hi, exp_lo;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];
  int   lat, d0;

  initial begin
    vecs[0] = '{"mult_7_m3",   1'b1, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
    vecs[1] = '{"div_m7_2",    1'b0, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 35};
    vecs[2] = '{"mult_3_4",    1'b1, 32'd3,          32'd4,        32'd0,        32'd12,       34};
    vecs[3] = '{"div_100_7",   1'b0, 32'd100,        32'd7,        32'd2,        32'd14,       35};
    vecs[4] = '{"mult_2p16sq", 1'b1, 32'h00010000,   32'h00010000, 32'd1,        32'd0,        34};
    vecs[5] = '{"div_7_m2",    1'b0, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 35};

    bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
    bus.wr_hi = 0; bus.wr_lo = 0; bus.wr_data = 0;

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_md_a", bus.md_a, 32'd0);
    check("rst_md_reset", {31'd0, bus.md_reset}, 32'd1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_md_reset", {31'd0, bus.md_reset}, 32'd0);

    // table-driven operations
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(lat);
      check({vecs[i].name, "_lat"},  lat, vecs[i].exp_lat);
      check({vecs[i].name, "_hi"},   bus.hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"},   bus.lo, vecs[i].exp_lo);
      check({vecs[i].name, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({vecs[i].name, "_dz"},   {31'd0, bus.div_zero_exc}, 32'd0);
    end

    // operands change upstream while busy
    issue(1'b0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk); bus.rs_data = 32'hDEADBEEF; bus.rt_data = 32'd0;
    #1;
    check("chg_busy_mid", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    check("chg_md_a", bus.md_a, 32'd100);
    check("chg_hi", bus.hi, 32'd2);
    check("chg_lo", bus.lo, 32'd14);

    // divide by zero with HI/LO preloaded
    @(negedge clk); bus.wr_hi = 1; bus.wr_data = 32'h11;
    @(negedge clk); bus.wr_hi = 0; bus.wr_lo = 1; bus.wr_data = 32'h22;
    @(negedge clk); bus.wr_lo = 0;
    check("mthi", bus.hi, 32'h11);
    check("mtlo", bus.lo, 32'h22);
    mdr_seen = 0; mon_en = 1;
    issue(1'b0, 32'd5, 32'd0);
    check("dz_done", {31'd0, bus.done}, 32'd1);
    check("dz_exc", {31'd0, bus.div_zero_exc}, 32'd1);
    check("dz_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    check("dz_done_pulse", {31'd0, bus.done}, 32'd0);
    check("dz_exc_pulse", {31'd0, bus.div_zero_exc}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 0;
    check("dz_md_reset", {31'd0, mdr_seen}, 32'd0);
    check("dz_hi", bus.hi, 32'h11);
    check("dz_lo", bus.lo, 32'h22);

    // start and mthi while busy are ignored
    d0 = done_cnt;
    issue(1'b1, 32'd7, 32'hFFFFFFFD);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1; bus.op = 1; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
    bus.wr_hi = 1; bus.wr_data = 32'hAB;
    @(posedge clk); #1;
    bus.start = 0; bus.wr_hi = 0;
    check("col_hi_hold", bus.hi, 32'h11);
    wait_done(lat);
    check("col_md_a", bus.md_a, 32'd7);
    check("col_hi", bus.hi, 32'hFFFFFFFF);
    check("col_lo", bus.lo, 32'hFFFFFFEB);
    repeat (40) @(posedge clk);
    #1;
    check("col_single_done", done_cnt - d0, 32'd1);

    // mtlo coincident with an accepted start: start wins
    @(negedge clk);
    bus.start = 1; bus.op = 1; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
    bus.wr_lo = 1; bus.wr_data = 32'hDEAD;
    @(posedge clk); #1;
    bus.start = 0; bus.wr_lo = 0;
    check("wrlo_start_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    check("wrlo_lat", lat, 32'd34);
    check("wrlo_lo", bus.lo, 32'd12);

    // reset mid-RUN discards the operation
    issue(1'b1, 32'd7, 32'hFFFFFFFD);
    repeat (15) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    check("mrst_md_reset", {31'd0, bus.md_reset}, 32'd1);
    @(negedge clk); reset = 1'b0;
    #1;
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_hi", bus.hi, 32'd0);
    check("mrst_lo", bus.lo, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("mrst_no_done", done_cnt - d0, 32'd0);
    issue(1'b1, 32'd3, 32'd4);
    wait_done(lat);
    check("mrst_fresh_lat", lat, 32'd34);
    check("mrst_fresh_hi", bus.hi, 32'd0);
    check("mrst_fresh_lo", bus.lo, 32'd12);

    // back-to-back: new start in the done cycle
    issue(1'b1, 32'd7, 32'hFFFFFFFD);
    wait_done(lat);
    check("b2b_first_lat", lat, 32'd34);
    bus.start = 1; bus.op = 1; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
    @(posedge clk); #1;
    bus.start = 0;
    check("b2b_accept_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    check("b2b_second_lat", lat, 32'd34);
    check("b2b_hi", bus.hi, 32'd0);
    check("b2b_lo", bus.lo, 32'd700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
